// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector. It compares the last cfg_len received bits with a loaded pattern.
// It supports overlap and non-overlap modes and keeps a saturating match counter.
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W = 8,
   localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(3'b101);
   localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(3);
   localparam logic [LEN_W-1:0]   FULL_FILL   = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic               err_q, err_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [MAX_LEN-1:0] histShift;
   logic [MAX_LEN-1:0] lenMask;
   logic [LEN_W:0]     fillPlus;
   logic [LEN_W-1:0]   fillInc;
   logic               hit;

   // The candidate history includes the bit arriving on this edge, so a match registers one cycle after the completing bit.
   always_comb begin
      histShift = {hist_q[MAX_LEN-2:0], in_bit};
      lenMask   = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         lenMask[i] = (i < int'(len_q));
      end
      fillPlus = {1'b0, fill_q} + (LEN_W+1)'(1);
      fillInc  = (fill_q == FULL_FILL) ? fill_q : fill_q + LEN_W'(1);
      hit      = in_valid && !cfg_load && !err_q
                 && (fillPlus >= {1'b0, len_q})
                 && (((histShift ^ pattern_q) & lenMask) == '0);
   end

   // Next-state logic: a configuration load takes priority over data and clears the history.
   always_comb begin
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      err_d     = err_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      match_d   = 1'b0;
      count_d   = count_q;

      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         err_d     = (cfg_len < LEN_W'(2)) || (cfg_len > FULL_FILL);
         hist_d    = '0;
         fill_d    = '0;
      end else if (in_valid) begin
         hist_d  = histShift;
         fill_d  = fillInc;
         match_d = hit;
         if (hit && !overlap_q) begin
            hist_d = '0;
            fill_d = '0;
         end
      end

      if (cnt_clr) begin
         count_d = '0;
      end else if (hit && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= RST_PATTERN;
         len_q     <= RST_LEN;
         overlap_q <= 1'b1;
         err_q     <= 1'b0;
         hist_q    <= '0;
         fill_q    <= '0;
         match_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         err_q     <= err_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         count_q   <= count_d;
      end
   end

   assign match       = match_q;
   assign match_count = count_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog. A table of directed vectors is followed by hand-written reset and saturation sequences.
// A second instance with CNT_W=2 shares the same inputs and covers counter saturation.
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cnt_clr;
   logic       match, match2;
   logic [7:0] match_count;
   logic [1:0] match_count2;
   logic       cfg_err, cfg_err2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       load;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       clr;
      logic       vld;
      logic       bitIn;
      logic       expMatch;
      logic [7:0] expCount;
      logic       expErr;
   } vec_t;

   vec_t vecs[$];

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .match(match), .match_count(match_count), .cfg_err(cfg_err)
   );

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .match(match2), .match_count(match_count2), .cfg_err(cfg_err2)
   );

   always #5 clk = ~clk;

   function automatic vec_t bitV(logic b, logic v, logic clr, logic m, logic [7:0] c, logic e);
      vec_t r;
      r = '{load: 1'b0, pat: 8'h00, len: 4'd0, ovl: 1'b0, clr: clr, vld: v, bitIn: b,
            expMatch: m, expCount: c, expErr: e};
      return r;
   endfunction

   function automatic vec_t loadV(logic [7:0] p, logic [3:0] l, logic o, logic v,
                                  logic [7:0] c, logic e);
      vec_t r;
      r = '{load: 1'b1, pat: p, len: l, ovl: o, clr: 1'b0, vld: v, bitIn: 1'b1,
            expMatch: 1'b0, expCount: c, expErr: e};
      return r;
   endfunction

   // Drives one vector after a falling edge and returns just after the following rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      cfg_load    = v.load;
      cfg_pattern = v.pat;
      cfg_len     = v.len;
      cfg_overlap = v.ovl;
      cnt_clr     = v.clr;
      in_valid    = v.vld;
      in_bit      = v.bitIn;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
      cnt_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_match", {31'd0, match}, 32'd0);
      checkOutput("rst_count", {24'd0, match_count}, 32'd0);
      checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Default 101 detector with overlap
      vecs.push_back(bitV(1, 1, 0, 0, 0, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 0, 0));
      vecs.push_back(bitV(1, 1, 0, 1, 1, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 1, 0));
      vecs.push_back(bitV(1, 1, 0, 1, 2, 0));
      // Non-overlap 101; upper pattern bits are ignored
      vecs.push_back(loadV(8'hF5, 4'd3, 0, 0, 2, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 2, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 2, 0));
      vecs.push_back(bitV(1, 1, 0, 1, 3, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 3, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 3, 0));
      // len=8 pattern A5 with idle cycles in between (idle in_bit=1 must be ignored)
      vecs.push_back(loadV(8'hA5, 4'd8, 1, 0, 3, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 3, 0)); vecs.push_back(bitV(1, 0, 0, 0, 3, 0));
      vecs.push_back(bitV(1, 1, 0, 1, 4, 0)); vecs.push_back(bitV(1, 0, 0, 0, 4, 0));
      // Illegal lengths 0, 9, 1 suppress matches; legal reload clears the error
      vecs.push_back(loadV(8'h00, 4'd0, 1, 0, 4, 1));
      vecs.push_back(bitV(1, 1, 0, 0, 4, 1));
      vecs.push_back(bitV(0, 1, 0, 0, 4, 1));
      vecs.push_back(bitV(1, 1, 0, 0, 4, 1));
      vecs.push_back(loadV(8'h05, 4'd9, 1, 0, 4, 1));
      vecs.push_back(loadV(8'h05, 4'd1, 1, 0, 4, 1));
      vecs.push_back(loadV(8'h05, 4'd3, 1, 0, 4, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 4, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 4, 0));
      vecs.push_back(bitV(1, 1, 0, 1, 5, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 5, 0));
      vecs.push_back(bitV(1, 1, 1, 1, 0, 0));
      // Load with in_valid on the same edge discards the bit
      vecs.push_back(bitV(1, 1, 0, 0, 0, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 0, 0));
      vecs.push_back(loadV(8'h05, 4'd3, 1, 1, 0, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 0, 0));
      vecs.push_back(bitV(1, 1, 0, 0, 0, 0));
      vecs.push_back(bitV(0, 1, 0, 0, 0, 0));
      vecs.push_back(bitV(1, 1, 0, 1, 1, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_match", i), {31'd0, match}, {31'd0, vecs[i].expMatch});
         checkOutput($sformatf("v%0d_count", i), {24'd0, match_count}, {24'd0, vecs[i].expCount});
         checkOutput($sformatf("v%0d_err", i), {31'd0, cfg_err}, {31'd0, vecs[i].expErr});
      end

      // Two-bit counter saturates at 3, and cnt_clr wins over a coincident match
      doReset();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(bitV(((i % 2) == 0), 1, 0, 0, 0, 0));
         checkOutput($sformatf("sat%0d_match", i), {31'd0, match2},
                     {31'd0, (i >= 2) && ((i % 2) == 0)});
         checkOutput($sformatf("sat%0d_count", i), {30'd0, match_count2},
                     (i < 2) ? 32'd0 : ((i / 2) > 3 ? 32'd3 : 32'(i / 2)));
      end
      applyStimulus(bitV(0, 1, 0, 0, 0, 0));
      applyStimulus(bitV(1, 1, 1, 0, 0, 0));
      checkOutput("satclr_match", {31'd0, match2}, 32'd1);
      checkOutput("satclr_count", {30'd0, match_count2}, 32'd0);
      checkOutput("satclr_count8", {24'd0, match_count}, 32'd0);

      // Asynchronous reset clears a live match pulse between edges
      doReset();
      applyStimulus(bitV(1, 1, 0, 0, 0, 0));
      applyStimulus(bitV(0, 1, 0, 0, 0, 0));
      applyStimulus(bitV(1, 1, 0, 0, 0, 0));
      checkOutput("pre_rst_match", {31'd0, match}, 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_match", {31'd0, match}, 32'd0);
      checkOutput("async_count", {24'd0, match_count}, 32'd0);
      #1 rst = 1'b0;

      // Partial sequence interrupted by reset is discarded
      applyStimulus(bitV(1, 1, 0, 0, 0, 0));
      applyStimulus(bitV(0, 1, 0, 0, 0, 0));
      #1 rst = 1'b1;
      #1;
      checkOutput("mid_rst_match", {31'd0, match}, 32'd0);
      #1 rst = 1'b0;
      applyStimulus(bitV(1, 1, 0, 0, 0, 0));
      checkOutput("post_rst_b1", {31'd0, match}, 32'd0);
      applyStimulus(bitV(0, 1, 0, 0, 0, 0));
      checkOutput("post_rst_b2", {31'd0, match}, 32'd0);
      applyStimulus(bitV(1, 1, 0, 0, 0, 0));
      checkOutput("post_rst_b3", {31'd0, match}, 32'd1);
      checkOutput("post_rst_count", {24'd0, match_count}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
